pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Consumer side of the system PLL: drives the PLL rst input and watches its locked output.
//  Pulses the PLL reset and waits for lock, retrying on timeout. Requires a stable-lock
//  window before releasing the synchronous system reset to the core clock domains.
//  Runs on the PLL reference clock, so it stays alive while the PLL output clocks are down.
// PARAMETERS
//  RST_PULSE      16     refclk cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT   50000  refclk cycles allowed for lock after pll_rst falls (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   consecutive synchronized-lock cycles required before release
//  MAX_RETRY      4      failed attempts before giving up (1..15)
//  SYNC_STAGES    2      flops in the locked synchronizer (>=2)
// PORTS
//  refclk      in   1  reference clock, 50 MHz; sole clock of the block
//  rst         in   1  asynchronous, active-high reset
//  locked      in   1  PLL locked, asynchronous to refclk
//  restart     in   1  sync pulse: abort and re-run the full sequence, retry count cleared
//  pll_rst     out  1  to PLL rst input
//  sys_reset   out  1  active-high reset to downstream logic; low only in RUN
//  ready       out  1  high only in RUN
//  fail        out  1  high in FAIL (MAX_RETRY timeouts exhausted)
//  retry_cnt   out  4  timeouts in the current sequence
//  loss_cnt    out  8  lock losses seen in RUN since rst; saturates at 255
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: pll_rst=1, sys_reset=1, ready=0, fail=0, retry_cnt=0, loss_cnt=0.
//    State is PLLRST, timer=0, synchronizer cleared to 0.
//  - lock_s is locked passed through SYNC_STAGES flops. FSM reaction is SYNC_STAGES+1 cycles
//    after a locked edge.
//  - PLLRST: pll_rst=1, sys_reset=1. Timer counts 0..RST_PULSE-1, then goes to WAIT with
//    timer=0.
//  - WAIT: pll_rst=0. lock_s=1 goes to STABLE with timer=0.
//    - timer==LOCK_TIMEOUT-1 with no lock: retry_cnt++.
//    - If the new count equals MAX_RETRY, go to FAIL; otherwise go to PLLRST.
//  - STABLE: timer counts while lock_s=1.
//    - lock_s=0 goes to WAIT with timer=0. This is a glitch, not a timeout; retry_cnt unchanged.
//    - timer==STABLE_CYCLES-1 goes to RUN.
//  - RUN: sys_reset=0, ready=1. Both take effect on the cycle after entry.
//    - lock_s=0 sets sys_reset=1 and ready=0 on the next edge, increments loss_cnt
//      (saturating), clears retry_cnt and goes to PLLRST.
//  - FAIL: pll_rst=0, sys_reset=1, fail=1. Terminal until rst or restart.
//  - restart=1 in any state goes to PLLRST with timer=0, retry_cnt=0 and fail=0 next cycle.
//    loss_cnt is preserved.
//  - Priority within one cycle: rst > restart > lock loss / timeout > normal count.
//  - restart and lock loss in RUN on the same cycle: restart wins and loss_cnt is NOT
//    incremented.
//  - Timer width is sized for max(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES). It never wraps:
//    every terminal value forces a transition.
//  - rst asserted mid-sequence: all state returns to reset values immediately (async).
//  - sys_reset never goes low unless lock_s has held for STABLE_CYCLES consecutive cycles.
// TESTING  (RST_PULSE=4, LOCK_TIMEOUT=100, STABLE_CYCLES=20, MAX_RETRY=3, SYNC_STAGES=2)
//  1. Clean lock: release rst; locked=1 for 30 cycles after pll_rst falls.
//     -> pll_rst high exactly 4 cycles. ready=1, sys_reset=0 at 30+2+1+20+1 cycles after
//     the pll_rst fall.
//  2. No lock: locked=0 forever.
//     -> three 4-cycle pll_rst pulses, 100 cycles apart; retry_cnt 1,2,3.
//     -> fail=1 after the third timeout; pll_rst stays 0 and sys_reset stays 1.
//  3. Glitch in STABLE: locked drops for 1 cycle at stable count 10.
//     -> back to WAIT, retry_cnt=0. RUN only after 20 further clean cycles.
//  4. Loss in RUN: in RUN, drop locked.
//     -> sys_reset=1 and ready=0 within SYNC_STAGES+1 cycles; loss_cnt=1; new pll_rst pulse.
//  5. Restart: pulse restart in FAIL, and separately together with a lock drop in RUN.
//     -> fail=0, retry_cnt=0, PLLRST entered; loss_cnt unchanged in the simultaneous case.
//  6. Async rst mid-STABLE: assert rst between clock edges.
//     -> pll_rst=1, sys_reset=1, ready=0 immediately, without waiting for a refclk edge.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Reference-clock sequencer for the system PLL: pulses pll_rst, waits for lock with retries,
// and releases the downstream system reset only after a stable-lock window.
module pll_reset_sequencer #(
    parameter int unsigned RST_PULSE     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int unsigned TMAX_A = (RST_PULSE > LOCK_TIMEOUT) ? RST_PULSE : LOCK_TIMEOUT;
    localparam int unsigned TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
    localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] RST_LAST    = TW'(RST_PULSE - 1);
    localparam logic [TW-1:0] LOCK_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

    localparam logic [2:0] ST_PLLRST = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_STABLE = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3:0]             retry_q, retry_d;
    logic [7:0]             loss_q, loss_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   run_next;
    logic                   pll_rst_q, sys_reset_q, ready_q, fail_q;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        if (restart) begin
            state_d = ST_PLLRST;
            timer_d = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_PLLRST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        timer_d = '0;
                    end else if (timer_q == LOCK_LAST) begin
                        retry_d = retry_q + 4'd1;
                        timer_d = '0;
                        state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_PLLRST;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_STABLE: begin
                    // A drop here is a glitch, not a timeout: retry count is left alone.
                    if (!lock_s) begin
                        state_d = ST_WAIT;
                        timer_d = '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_PLLRST;
                        timer_d = '0;
                        retry_d = '0;
                        if (loss_q != 8'hff) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                end
                default: begin
                    state_d = ST_PLLRST;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Release only once RUN has been held for a full cycle; any exit drops it on that edge.
    assign run_next = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLLRST;
            timer_q     <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            sync_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], locked};
            pll_rst_q   <= (state_d == ST_PLLRST);
            sys_reset_q <= !run_next;
            ready_q     <= run_next;
            fail_q      <= (state_d == ST_FAIL);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_reset = sys_reset_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: stimulus schedules expected output snapshots by
// cycle number; a monitor pops and compares them on the falling edge.
module tb_pll_reset_sequencer;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_reset, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    pll_reset_sequencer #(
        .RST_PULSE    (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(20),
        .MAX_RETRY    (3),
        .SYNC_STAGES  (2)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .sys_reset(sys_reset),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 refclk = ~refclk;

    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        string       tag;
        logic [15:0] v;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        me;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] act;

    assign act = {pll_rst, sys_reset, ready, fail, retry_cnt, loss_cnt};

    task automatic expect_at(input int at, input string tag, input logic pr, input logic sr,
                             input logic rdy, input logic fl, input logic [3:0] rc,
                             input logic [7:0] lc);
        exp_t e;
        int   i;
        e.at  = at;
        e.tag = tag;
        e.v   = {pr, sr, rdy, fl, rc, lc};
        i = 0;
        while (i < exp_q.size() && exp_q[i].at <= at) i++;
        exp_q.insert(i, e);
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) begin
            @(posedge refclk);
            #1;
        end
    endtask

    always @(negedge refclk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
            me = exp_q.pop_front();
            n_cmp++;
            if (me.at != cyc || act !== me.v) begin
                n_bad++;
                $display("FAIL %s cyc=%0d(sched %0d): got pr=%b sr=%b rdy=%b fail=%b rc=%0d lc=%0d, want pr=%b sr=%b rdy=%b fail=%b rc=%0d lc=%0d",
                         me.tag, cyc, me.at, act[15], act[14], act[13], act[12], act[11:8],
                         act[7:0], me.v[15], me.v[14], me.v[13], me.v[12], me.v[11:8],
                         me.v[7:0]);
            end
        end
    end

    int b, f, g, h;

    initial begin
        tick_to(3);
        b = cyc;
        f = b + 4;      // pll_rst falls: WAIT entered
        g = f + 67;     // WAIT re-entered after the loss-in-RUN pulse
        h = g + 52;     // WAIT entered after restart+drop; no lock from here

        // Reset state and first pll_rst pulse
        expect_at(b,      "reset_state",   1, 1, 0, 0, 0, 0);
        expect_at(b + 3,  "pulse_hold",    1, 1, 0, 0, 0, 0);
        expect_at(f,      "pulse_fall",    0, 1, 0, 0, 0, 0);
        rst = 1'b0;

        // Clean lock: locked rises 30 cycles after the fall, ready at +54
        expect_at(f + 53, "run_entry",     0, 1, 0, 0, 0, 0);
        expect_at(f + 54, "run_ready",     0, 0, 1, 0, 0, 0);
        tick_to(f + 30);
        locked = 1'b1;

        // Loss in RUN
        expect_at(f + 62, "loss_pre",      0, 0, 1, 0, 0, 0);
        expect_at(f + 63, "loss_react",    1, 1, 0, 0, 0, 1);
        expect_at(f + 66, "loss_pulse",    1, 1, 0, 0, 0, 1);
        expect_at(g,      "loss_wait",     0, 1, 0, 0, 0, 1);
        tick_to(f + 60);
        locked = 1'b0;

        // Lock, then a one-cycle glitch at stable count 10
        tick_to(g + 5);
        locked = 1'b1;
        expect_at(g + 18, "glitch_stable", 0, 1, 0, 0, 0, 1);
        expect_at(g + 19, "glitch_wait",   0, 1, 0, 0, 0, 1);
        expect_at(g + 30, "glitch_recnt",  0, 1, 0, 0, 0, 1);
        expect_at(g + 40, "glitch_run",    0, 1, 0, 0, 0, 1);
        expect_at(g + 41, "glitch_ready",  0, 0, 1, 0, 0, 1);
        tick_to(g + 16);
        locked = 1'b0;
        tick_to(g + 17);
        locked = 1'b1;

        // Restart coinciding with lock loss in RUN: loss_cnt must not move
        expect_at(g + 47, "rs_drop_pre",   0, 0, 1, 0, 0, 1);
        expect_at(g + 48, "rs_drop",       1, 1, 0, 0, 0, 1);
        expect_at(h,      "rs_drop_wait",  0, 1, 0, 0, 0, 1);
        tick_to(g + 45);
        locked = 1'b0;
        tick_to(g + 47);
        restart = 1'b1;
        tick_to(g + 48);
        restart = 1'b0;

        // No lock: three timeouts then FAIL
        expect_at(h + 99,  "to1_pre",      0, 1, 0, 0, 0, 1);
        expect_at(h + 100, "to1",          1, 1, 0, 0, 1, 1);
        expect_at(h + 103, "to1_pulse",    1, 1, 0, 0, 1, 1);
        expect_at(h + 104, "to1_wait",     0, 1, 0, 0, 1, 1);
        expect_at(h + 203, "to2_pre",      0, 1, 0, 0, 1, 1);
        expect_at(h + 204, "to2",          1, 1, 0, 0, 2, 1);
        expect_at(h + 208, "to2_wait",     0, 1, 0, 0, 2, 1);
        expect_at(h + 307, "to3_pre",      0, 1, 0, 0, 2, 1);
        expect_at(h + 308, "to3_fail",     0, 1, 0, 1, 3, 1);
        expect_at(h + 320, "fail_hold",    0, 1, 0, 1, 3, 1);

        // Restart from FAIL
        expect_at(h + 321, "rs_fail",      1, 1, 0, 0, 0, 1);
        expect_at(h + 325, "rs_fail_wait", 0, 1, 0, 0, 0, 1);
        tick_to(h + 320);
        restart = 1'b1;
        tick_to(h + 321);
        restart = 1'b0;

        // Async rst mid-STABLE, checked before the next refclk edge
        tick_to(h + 330);
        locked = 1'b1;
        expect_at(h + 339, "stable_pre",   0, 1, 0, 0, 0, 1);
        tick_to(h + 340);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pll_rst !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pll_rst: pll_rst=%b, want 1 before refclk edge", pll_rst);
        end
        n_cmp++;
        if (sys_reset !== 1'b1) begin
            n_bad++;
            $display("FAIL async_sys_reset: sys_reset=%b, want 1 before refclk edge", sys_reset);
        end
        n_cmp++;
        if (ready !== 1'b0) begin
            n_bad++;
            $display("FAIL async_ready: ready=%b, want 0 before refclk edge", ready);
        end
        expect_at(h + 340, "async_rst",    1, 1, 0, 0, 0, 0);
        expect_at(h + 346, "rel_wait",     0, 1, 0, 0, 0, 0);
        expect_at(h + 367, "rel_run",      0, 1, 0, 0, 0, 0);
        expect_at(h + 368, "rel_ready",    0, 0, 1, 0, 0, 0);
        tick_to(h + 342);
        rst = 1'b0;

        tick_to(h + 375);
        @(negedge refclk);
        #1;
        while (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never checked, still pending at cyc=%0d", me.tag, cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
